// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M multiply/divide unit for the execute stage.
//
// Accepts an M-extension bundle (OP opcode, funct7 = 0000001) while idle.
// The unit then spends 32 cycles computing one product or quotient bit per
// cycle. Divide-by-zero and signed overflow skip the iteration and go
// straight to DONE. The result is presented for exactly one cycle, together
// with the latched write-back controls.
//
// Ports:
//   clk              rising-edge clock
//   resetIn          asynchronous active-low reset
//   flushIn          synchronous abort of an in-flight operation
//   validIn          operand bundle valid this cycle
//   dataAlu1/2       rs1 / rs2 values
//   ALUopcodeAlu     opcode
//   ALUFunc3Alu      funct3, selects the operation
//   ALUFunc7Alu      funct7
//   writeEnableIn    register write enable of the bundle
//   writeBackAddrIn  destination register of the bundle
//   busy             unit occupied, upstream must stall
//   resultValid      one-cycle result strobe
//   result           product high/low half, quotient or remainder
//   writeEnableOut   latched write enable, qualified by resultValid
//   writeBackAddrOut latched destination register
module alu_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            resetIn,
    input  logic            flushIn,
    input  logic            validIn,
    input  logic [XLEN-1:0] dataAlu1,
    input  logic [XLEN-1:0] dataAlu2,
    input  logic [6:0]      ALUopcodeAlu,
    input  logic [2:0]      ALUFunc3Alu,
    input  logic [6:0]      ALUFunc7Alu,
    input  logic            writeEnableIn,
    input  logic [4:0]      writeBackAddrIn,
    output logic            busy,
    output logic            resultValid,
    output logic [XLEN-1:0] result,
    output logic            writeEnableOut,
    output logic [4:0]      writeBackAddrOut
);

    localparam logic [6:0]      OPCODE_OP = 7'b0110011;
    localparam logic [6:0]      FUNCT7_M  = 7'b0000001;
    localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [4:0]        count;
    logic [2*XLEN-1:0] acc;     // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              neg_a;
    logic              neg_b;
    logic [2:0]        op;
    logic              we_latched;

    // Operand decode for the bundle currently on the inputs.
    logic              in_is_mul;
    logic              in_a_signed;
    logic              in_b_signed;
    logic              in_neg_a;
    logic              in_neg_b;
    logic [XLEN-1:0]   in_mag_a;
    logic [XLEN-1:0]   in_mag_b;
    logic              div_by_zero;
    logic              div_overflow;
    logic              fast_path;
    logic [XLEN-1:0]   fast_result;
    logic              accept;

    // One iteration step and the final sign fix-up.
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_shift;
    logic [XLEN-1:0]   rem_diff;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   remd;
    logic [XLEN-1:0]   final_result;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        in_is_mul    = ~ALUFunc3Alu[2];
        in_a_signed  = 1'b0;
        in_b_signed  = 1'b0;
        fast_result  = '0;

        if (in_is_mul) begin
            // MUL/MULH: both signed; MULHSU: rs1 only; MULHU: neither.
            // MUL's low half is identical for any signedness.
            in_a_signed = (ALUFunc3Alu[1:0] != 2'b11);
            in_b_signed = ~ALUFunc3Alu[1];
        end else begin
            in_a_signed = ~ALUFunc3Alu[0];
            in_b_signed = ~ALUFunc3Alu[0];
        end

        in_neg_a = in_a_signed & dataAlu1[XLEN-1];
        in_neg_b = in_b_signed & dataAlu2[XLEN-1];
        // INT_MIN negates to itself, which is still the correct unsigned magnitude.
        in_mag_a = in_neg_a ? -dataAlu1 : dataAlu1;
        in_mag_b = in_neg_b ? -dataAlu2 : dataAlu2;

        div_by_zero  = ~in_is_mul & (dataAlu2 == '0);
        div_overflow = ~in_is_mul & ~ALUFunc3Alu[0]
                     & (dataAlu1 == INT_MIN) & (dataAlu2 == '1);
        fast_path    = div_by_zero | div_overflow;

        // funct3[1] distinguishes remainder from quotient.
        if (div_by_zero)
            fast_result = ALUFunc3Alu[1] ? dataAlu1 : '1;
        else
            fast_result = ALUFunc3Alu[1] ? '0 : INT_MIN;

        accept = validIn & (ALUopcodeAlu == OPCODE_OP) & (ALUFunc7Alu == FUNCT7_M)
               & (state == IDLE) & ~flushIn;
    end

    always_comb begin
        // Shift-add: conditionally add the multiplicand to the high half,
        // then shift the whole accumulator (with carry) right by one.
        mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : '0);

        // Restoring division: shift the next dividend bit into the
        // remainder and subtract the divisor if it fits.
        rem_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        rem_diff  = rem_shift[XLEN-1:0] - mag_b;

        if (op[2] == 1'b0)
            acc_next = {mul_sum, acc[XLEN-1:1]};
        else if (rem_shift >= {1'b0, mag_b})
            acc_next = {rem_diff, acc[XLEN-2:0], 1'b1};
        else
            acc_next = {rem_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};

        // Unsigned ops never set the sign flags, so one fix-up serves all.
        prod = (neg_a ^ neg_b) ? -acc_next : acc_next;
        quot = (neg_a ^ neg_b) ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
        remd = neg_a ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];

        case (op)
            3'b000:                 final_result = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_result = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_result = quot;
            default:                final_result = remd;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetIn) begin
        if (!resetIn) begin
            state            <= IDLE;
            count            <= '0;
            acc              <= '0;
            mag_a            <= '0;
            mag_b            <= '0;
            neg_a            <= 1'b0;
            neg_b            <= 1'b0;
            op               <= '0;
            we_latched       <= 1'b0;
            writeBackAddrOut <= '0;
            result           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op               <= ALUFunc3Alu;
                        we_latched       <= writeEnableIn;
                        writeBackAddrOut <= writeBackAddrIn;
                        neg_a            <= in_neg_a;
                        neg_b            <= in_neg_b;
                        mag_a            <= in_mag_a;
                        mag_b            <= in_mag_b;
                        count            <= '0;
                        if (fast_path) begin
                            result <= fast_result;
                            state  <= DONE;
                        end else begin
                            // Multiplier (mul) or dividend (div) starts in the low half.
                            acc   <= {{XLEN{1'b0}}, in_is_mul ? in_mag_b : in_mag_a};
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flushIn) begin
                        state <= IDLE;
                    end else begin
                        acc   <= acc_next;
                        count <= count + 5'd1;
                        if (count == 5'd31) begin
                            result <= final_result;
                            state  <= DONE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy           = (state != IDLE);
    assign resultValid    = (state == DONE);
    assign writeEnableOut = we_latched & resultValid;

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed-vector bench for alu_muldiv.
//
// Inputs are driven on the falling edge and outputs sampled on the falling
// edge, so the DUT sees stable values at each rising edge. Expected results
// are hand-computed constants in the stimulus calls below.
module tb_alu_muldiv;

    logic        clk;
    logic        resetIn;
    logic        flushIn;
    logic        validIn;
    logic [31:0] dataAlu1;
    logic [31:0] dataAlu2;
    logic [6:0]  ALUopcodeAlu;
    logic [2:0]  ALUFunc3Alu;
    logic [6:0]  ALUFunc7Alu;
    logic        writeEnableIn;
    logic [4:0]  writeBackAddrIn;
    logic        busy;
    logic        resultValid;
    logic [31:0] result;
    logic        writeEnableOut;
    logic [4:0]  writeBackAddrOut;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [6:0] OP_OP  = 7'b0110011;
    localparam logic [6:0] F7_M   = 7'b0000001;
    localparam logic [6:0] F7_ALU = 7'b0000000;

    alu_muldiv #(.XLEN(32)) dut (
        .clk              (clk),
        .resetIn          (resetIn),
        .flushIn          (flushIn),
        .validIn          (validIn),
        .dataAlu1         (dataAlu1),
        .dataAlu2         (dataAlu2),
        .ALUopcodeAlu     (ALUopcodeAlu),
        .ALUFunc3Alu      (ALUFunc3Alu),
        .ALUFunc7Alu      (ALUFunc7Alu),
        .writeEnableIn    (writeEnableIn),
        .writeBackAddrIn  (writeBackAddrIn),
        .busy             (busy),
        .resultValid      (resultValid),
        .result           (result),
        .writeEnableOut   (writeEnableOut),
        .writeBackAddrOut (writeBackAddrOut)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Present one bundle for a single cycle; returns at the falling edge
    // right after the accept edge. Inputs are then scrambled so the DUT
    // must rely on what it latched.
    task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [6:0] f7, input logic we, input logic [4:0] rd);
        validIn         = 1'b1;
        ALUopcodeAlu    = OP_OP;
        ALUFunc3Alu     = f3;
        ALUFunc7Alu     = f7;
        dataAlu1        = a;
        dataAlu2        = b;
        writeEnableIn   = we;
        writeBackAddrIn = rd;
        @(negedge clk);
        validIn         = 1'b0;
        dataAlu1        = 32'hDEADBEEF;
        dataAlu2        = 32'h12345678;
        ALUFunc3Alu     = ~f3;
        writeEnableIn   = ~we;
        writeBackAddrIn = ~rd;
    endtask

    // Wait (bounded) for resultValid, counting falling edges since the
    // accept edge starting at 'start', then check the result bundle.
    task automatic expect_result(input string tag, input logic [31:0] exp, input logic we,
                                 input logic [4:0] rd, input int exp_lat, input int start);
        int  lat    = 0;
        int  busy_n = 0;
        bit  seen   = 1'b0;
        for (int i = start; i <= 60; i++) begin
            if (busy) busy_n++;
            if (resultValid) begin
                seen = 1'b1;
                lat  = i;
                break;
            end
            @(negedge clk);
        end
        check({tag, ".valid"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
            check({tag, ".busy_cycles"}, 32'(busy_n), 32'(exp_lat - start + 1));
            check({tag, ".result"}, result, exp);
            check({tag, ".we"}, 32'(writeEnableOut), 32'(we));
            check({tag, ".rd"}, 32'(writeBackAddrOut), 32'(rd));
            @(negedge clk);
            check({tag, ".after_done"}, {29'b0, resultValid, busy, writeEnableOut}, 32'd0);
        end
    endtask

    // Count cycles over a window in which busy or resultValid is seen.
    task automatic expect_quiet(input string tag, input int cycles);
        int hits = 0;
        for (int i = 0; i < cycles; i++) begin
            if (busy || resultValid) hits++;
            @(negedge clk);
        end
        check(tag, 32'(hits), 32'd0);
    endtask

    initial begin
        resetIn         = 1'b0;
        flushIn         = 1'b0;
        validIn         = 1'b0;
        dataAlu1        = '0;
        dataAlu2        = '0;
        ALUopcodeAlu    = '0;
        ALUFunc3Alu     = '0;
        ALUFunc7Alu     = '0;
        writeEnableIn   = 1'b0;
        writeBackAddrIn = '0;

        repeat (2) @(negedge clk);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.valid", 32'(resultValid), 32'd0);
        check("reset.result", result, 32'h0);
        check("reset.we", 32'(writeEnableOut), 32'd0);
        check("reset.rd", 32'(writeBackAddrOut), 32'd0);
        resetIn = 1'b1;
        @(negedge clk);

        // Multiplies
        send(3'b000, 32'd7, 32'hFFFFFFFD, F7_M, 1'b1, 5'd9);
        expect_result("mul_7_m3", 32'hFFFFFFEB, 1'b1, 5'd9, 33, 1);
        send(3'b001, 32'h80000000, 32'h80000000, F7_M, 1'b1, 5'd10);
        expect_result("mulh_min_min", 32'h40000000, 1'b1, 5'd10, 33, 1);
        send(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, F7_M, 1'b1, 5'd11);
        expect_result("mulhu_max", 32'hFFFFFFFE, 1'b1, 5'd11, 33, 1);
        send(3'b010, 32'hFFFFFFFF, 32'd2, F7_M, 1'b1, 5'd12);
        expect_result("mulhsu_m1_2", 32'hFFFFFFFF, 1'b1, 5'd12, 33, 1);
        send(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, F7_M, 1'b0, 5'd13);
        expect_result("mul_m1_m1_nowe", 32'h00000001, 1'b0, 5'd13, 33, 1);

        // Divides
        send(3'b100, 32'hFFFFFFF9, 32'd2, F7_M, 1'b1, 5'd9);
        expect_result("div_m7_2", 32'hFFFFFFFD, 1'b1, 5'd9, 33, 1);
        send(3'b110, 32'hFFFFFFF9, 32'd2, F7_M, 1'b1, 5'd9);
        expect_result("rem_m7_2", 32'hFFFFFFFF, 1'b1, 5'd9, 33, 1);
        send(3'b101, 32'd100, 32'd7, F7_M, 1'b1, 5'd9);
        expect_result("divu_100_7", 32'd14, 1'b1, 5'd9, 33, 1);
        send(3'b111, 32'd100, 32'd7, F7_M, 1'b1, 5'd9);
        expect_result("remu_100_7", 32'd2, 1'b1, 5'd9, 33, 1);
        send(3'b100, 32'd20, 32'hFFFFFFFD, F7_M, 1'b1, 5'd14);
        expect_result("div_20_m3", 32'hFFFFFFFA, 1'b1, 5'd14, 33, 1);
        send(3'b110, 32'd20, 32'hFFFFFFFD, F7_M, 1'b1, 5'd15);
        expect_result("rem_20_m3", 32'd2, 1'b1, 5'd15, 33, 1);

        // Fast paths
        send(3'b101, 32'd5, 32'd0, F7_M, 1'b1, 5'd16);
        expect_result("divu_5_0", 32'hFFFFFFFF, 1'b1, 5'd16, 1, 1);
        send(3'b110, 32'd5, 32'd0, F7_M, 1'b1, 5'd17);
        expect_result("rem_5_0", 32'd5, 1'b1, 5'd17, 1, 1);
        send(3'b100, 32'h80000000, 32'hFFFFFFFF, F7_M, 1'b1, 5'd18);
        expect_result("div_ovf", 32'h80000000, 1'b1, 5'd18, 1, 1);
        send(3'b110, 32'h80000000, 32'hFFFFFFFF, F7_M, 1'b1, 5'd19);
        expect_result("rem_ovf", 32'h00000000, 1'b1, 5'd19, 1, 1);

        // Non-M bundle is ignored
        send(3'b000, 32'd3, 32'd4, F7_ALU, 1'b1, 5'd20);
        expect_quiet("non_m_ignored", 36);

        // M op presented while busy is ignored
        send(3'b000, 32'd7, 32'd3, F7_M, 1'b1, 5'd5);
        validIn         = 1'b1;
        ALUFunc3Alu     = 3'b101;
        ALUFunc7Alu     = F7_M;
        dataAlu1        = 32'd100;
        dataAlu2        = 32'd7;
        writeBackAddrIn = 5'd3;
        writeEnableIn   = 1'b1;
        @(negedge clk);
        validIn = 1'b0;
        expect_result("mul_while_busy", 32'd21, 1'b1, 5'd5, 33, 2);

        // Flush at CALC count 10, then immediate new accept
        send(3'b101, 32'd100, 32'd7, F7_M, 1'b1, 5'd7);
        repeat (10) @(negedge clk);
        flushIn = 1'b1;
        @(negedge clk);
        check("flush.busy", 32'(busy), 32'd0);
        check("flush.valid", 32'(resultValid), 32'd0);
        flushIn = 1'b0;
        send(3'b111, 32'd100, 32'd7, F7_M, 1'b1, 5'd4);
        expect_result("remu_after_flush", 32'd2, 1'b1, 5'd4, 33, 1);

        // Flush together with an accept in IDLE: flush wins
        flushIn = 1'b1;
        send(3'b000, 32'd7, 32'd3, F7_M, 1'b1, 5'd6);
        flushIn = 1'b0;
        expect_quiet("flush_vs_accept", 36);

        // Reset mid-CALC
        send(3'b000, 32'd7, 32'hFFFFFFFD, F7_M, 1'b1, 5'd9);
        repeat (5) @(negedge clk);
        resetIn = 1'b0;
        #1;
        check("midreset.busy", 32'(busy), 32'd0);
        check("midreset.valid", 32'(resultValid), 32'd0);
        check("midreset.result", result, 32'h0);
        check("midreset.we", 32'(writeEnableOut), 32'd0);
        check("midreset.rd", 32'(writeBackAddrOut), 32'd0);
        @(negedge clk);
        resetIn = 1'b1;
        expect_quiet("midreset.no_result", 40);

        // Unit still works after the mid-operation reset
        send(3'b100, 32'd20, 32'hFFFFFFFD, F7_M, 1'b1, 5'd21);
        expect_result("div_after_reset", 32'hFFFFFFFA, 1'b1, 5'd21, 33, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
